// File: rtl/gemm_cmd_regfile_if.sv
// Bus and command-queue signal bundle for gemm_cmd_regfile.
// slave is the register file's view; master is the host/sequencer side.
interface gemm_cmd_regfile_if #(
  parameter int unsigned DIM_W = 5
) ();
  logic             system_bus_en;
  logic             system_bus_rdwr;
  logic [31:0]      system_bus_addr;
  logic [31:0]      system_bus_wr_data;
  logic [31:0]      system_bus_rd_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a_addr;
  logic [31:0]      cmd_b_addr;
  logic [31:0]      cmd_c_addr;
  logic [31:0]      cmd_a_stride;
  logic [31:0]      cmd_b_stride;
  logic             cmd_first;
  logic             cmd_last;
  logic [DIM_W-1:0] cmd_msize;
  logic [DIM_W-1:0] cmd_ksize;
  logic [DIM_W-1:0] cmd_nsize;
  logic             engine_busy;

  modport slave (
    input  system_bus_en, system_bus_rdwr, system_bus_addr, system_bus_wr_data,
    input  cmd_ready, engine_busy,
    output system_bus_rd_data, cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr,
    output cmd_a_stride, cmd_b_stride, cmd_first, cmd_last, cmd_msize, cmd_ksize, cmd_nsize
  );

  modport master (
    output system_bus_en, system_bus_rdwr, system_bus_addr, system_bus_wr_data,
    output cmd_ready, engine_busy,
    input  system_bus_rd_data, cmd_valid, cmd_a_addr, cmd_b_addr, cmd_c_addr,
    input  cmd_a_stride, cmd_b_stride, cmd_first, cmd_last, cmd_msize, cmd_ksize, cmd_nsize
  );
endinterface

// File: rtl/gemm_cmd_regfile.sv
// Host-facing register window that stages GEMM tile parameters and queues one
// command per DIM write into a first-word-fall-through FIFO for the sequencer.
module gemm_cmd_regfile #(
  parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIM_W      = 5
) (
  input logic              clk,
  input logic              rst,
  gemm_cmd_regfile_if.slave bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0]      a_addr;
    logic [31:0]      b_addr;
    logic [31:0]      c_addr;
    logic [31:0]      a_stride;
    logic [31:0]      b_stride;
    logic             first;
    logic             last;
    logic [DIM_W-1:0] msize;
    logic [DIM_W-1:0] ksize;
    logic [DIM_W-1:0] nsize;
  } cmd_t;

  logic [31:0]     a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
  logic [31:0]     a_stride_q, a_stride_d, b_stride_q, b_stride_d;
  logic [1:0]      ctrl_q, ctrl_d;
  logic            ovf_q, ovf_d, dz_q, dz_d, full_q, full_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cmd_t            mem_q [FIFO_DEPTH];
  cmd_t            mem_d [FIFO_DEPTH];

  logic             hit, wr_hit, rd_hit, push_req, dim_zero, have_room, push, pop, done;
  logic [2:0]       off;
  logic [31:0]      wdata;
  logic [DIM_W-1:0] new_m, new_k, new_n;
  cmd_t             new_cmd;
  logic             unused_addr;

  assign hit       = bus.system_bus_en && (bus.system_bus_addr[31:5] == BASE_ADDR[31:5]);
  assign off       = bus.system_bus_addr[4:2];
  assign wdata     = bus.system_bus_wr_data;
  assign wr_hit    = hit && bus.system_bus_rdwr;
  assign rd_hit    = hit && !bus.system_bus_rdwr;
  assign push_req  = wr_hit && (off == 3'd6);
  assign new_m     = wdata[DIM_W-1:0];
  assign new_k     = wdata[2*DIM_W-1:DIM_W];
  assign new_n     = wdata[3*DIM_W-1:2*DIM_W];
  assign dim_zero  = (new_m == '0) || (new_k == '0) || (new_n == '0);
  assign pop       = (count_q != '0) && bus.cmd_ready;
  // A full queue still has room when its head leaves on the same edge.
  assign have_room = (count_q != DepthCnt) || pop;
  assign push      = push_req && !dim_zero && have_room;
  assign done      = (count_q == '0) && !bus.engine_busy;
  assign unused_addr = ^bus.system_bus_addr[1:0];

  always_comb begin
    new_cmd = '{a_addr: a_addr_q, b_addr: b_addr_q, c_addr: c_addr_q,
                a_stride: a_stride_q, b_stride: b_stride_q,
                first: ctrl_q[1], last: ctrl_q[0],
                msize: new_m, ksize: new_k, nsize: new_n};
  end

  always_comb begin
    a_addr_d   = a_addr_q;
    b_addr_d   = b_addr_q;
    c_addr_d   = c_addr_q;
    a_stride_d = a_stride_q;
    b_stride_d = b_stride_q;
    ctrl_d     = ctrl_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    if (wr_hit) begin
      case (off)
        3'd0: a_addr_d   = wdata;
        3'd1: b_addr_d   = wdata;
        3'd2: c_addr_d   = wdata;
        3'd3: a_stride_d = wdata;
        3'd4: b_stride_d = wdata;
        3'd5: ctrl_d     = wdata[1:0];
        3'd6: begin
          if (dim_zero)        dz_d  = 1'b1;
          else if (!have_room) ovf_d = 1'b1;
        end
        3'd7: begin
          if (wdata[1]) ovf_d = 1'b0;
          if (wdata[2]) dz_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = new_cmd;
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == DepthCnt);
  end

  // Any read updates the result register; misses read as zero.
  always_comb begin
    rd_data_d = rd_data_q;
    if (bus.system_bus_en && !bus.system_bus_rdwr) begin
      rd_data_d = '0;
      if (rd_hit) begin
        case (off)
          3'd0: rd_data_d = {31'b0, full_q};
          3'd1: rd_data_d = b_addr_q;
          3'd2: rd_data_d = c_addr_q;
          3'd3: rd_data_d = a_stride_q;
          3'd4: rd_data_d = b_stride_q;
          3'd5: rd_data_d = {30'b0, ctrl_q};
          3'd6: rd_data_d = {31'b0, done};
          3'd7: rd_data_d = {29'b0, dz_q, ovf_q, full_q};
          default: rd_data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      c_addr_q   <= '0;
      a_stride_q <= '0;
      b_stride_q <= '0;
      ctrl_q     <= '0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
      full_q     <= 1'b0;
      rd_data_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      a_addr_q   <= a_addr_d;
      b_addr_q   <= b_addr_d;
      c_addr_q   <= c_addr_d;
      a_stride_q <= a_stride_d;
      b_stride_q <= b_stride_d;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      dz_q       <= dz_d;
      full_q     <= full_d;
      rd_data_q  <= rd_data_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign bus.system_bus_rd_data = rd_data_q;
  assign bus.cmd_valid          = (count_q != '0);
  assign bus.cmd_a_addr         = mem_q[rd_ptr_q].a_addr;
  assign bus.cmd_b_addr         = mem_q[rd_ptr_q].b_addr;
  assign bus.cmd_c_addr         = mem_q[rd_ptr_q].c_addr;
  assign bus.cmd_a_stride       = mem_q[rd_ptr_q].a_stride;
  assign bus.cmd_b_stride       = mem_q[rd_ptr_q].b_stride;
  assign bus.cmd_first          = mem_q[rd_ptr_q].first;
  assign bus.cmd_last           = mem_q[rd_ptr_q].last;
  assign bus.cmd_msize          = mem_q[rd_ptr_q].msize;
  assign bus.cmd_ksize          = mem_q[rd_ptr_q].ksize;
  assign bus.cmd_nsize          = mem_q[rd_ptr_q].nsize;

endmodule

// File: tb/tb_gemm_cmd_regfile.sv
// Self-checking bench: directed scenarios plus random traffic compared each
// cycle against a queue-based model of the register window.
module tb_gemm_cmd_regfile;
  localparam logic [31:0] BASE = 32'h9000_0000;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a_addr;
    logic [31:0] b_addr;
    logic [31:0] c_addr;
    logic [31:0] a_stride;
    logic [31:0] b_stride;
    logic        first;
    logic        last;
    logic [4:0]  msize;
    logic [4:0]  ksize;
    logic [4:0]  nsize;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gemm_cmd_regfile_if #(.DIM_W(5)) bus_if ();

  gemm_cmd_regfile #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .DIM_W     (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks = 0;
  int failures = 0;

  // Model state
  ent_t        q[$];
  logic [31:0] m_a, m_b, m_c, m_as, m_bs, m_rd;
  logic [1:0]  m_ctrl;
  logic        m_ovf, m_dz;
  logic        mh;
  logic [2:0]  moff;
  logic [31:0] md;
  ent_t        me;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t dut_head();
    return {bus_if.cmd_a_addr, bus_if.cmd_b_addr, bus_if.cmd_c_addr, bus_if.cmd_a_stride,
            bus_if.cmd_b_stride, bus_if.cmd_first, bus_if.cmd_last, bus_if.cmd_msize,
            bus_if.cmd_ksize, bus_if.cmd_nsize};
  endfunction

  function automatic logic [31:0] dim(input logic [4:0] m, input logic [4:0] k,
                                      input logic [4:0] n);
    return {17'b0, n, k, m};
  endfunction

  // Reference model: reads see pre-edge state; pop happens before push so a
  // full queue with a departing head still accepts.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_a = 0; m_b = 0; m_c = 0; m_as = 0; m_bs = 0; m_ctrl = 0;
      m_ovf = 0; m_dz = 0; m_rd = 0;
    end else begin
      mh   = bus_if.system_bus_en && (bus_if.system_bus_addr[31:5] == BASE[31:5]);
      moff = bus_if.system_bus_addr[4:2];
      md   = bus_if.system_bus_wr_data;
      if (bus_if.system_bus_en && !bus_if.system_bus_rdwr) begin
        m_rd = 0;
        if (mh) begin
          case (moff)
            3'd0: m_rd = {31'b0, q.size() == DEPTH};
            3'd1: m_rd = m_b;
            3'd2: m_rd = m_c;
            3'd3: m_rd = m_as;
            3'd4: m_rd = m_bs;
            3'd5: m_rd = {30'b0, m_ctrl};
            3'd6: m_rd = {31'b0, q.size() == 0 && !bus_if.engine_busy};
            default: m_rd = {29'b0, m_dz, m_ovf, q.size() == DEPTH};
          endcase
        end
      end
      if (q.size() != 0 && bus_if.cmd_ready) void'(q.pop_front());
      if (mh && bus_if.system_bus_rdwr) begin
        case (moff)
          3'd0: m_a = md;
          3'd1: m_b = md;
          3'd2: m_c = md;
          3'd3: m_as = md;
          3'd4: m_bs = md;
          3'd5: m_ctrl = md[1:0];
          3'd6: begin
            if (md[4:0] == 0 || md[9:5] == 0 || md[14:10] == 0) m_dz = 1;
            else if (q.size() < DEPTH) begin
              me = '{a_addr: m_a, b_addr: m_b, c_addr: m_c, a_stride: m_as, b_stride: m_bs,
                     first: m_ctrl[1], last: m_ctrl[0],
                     msize: md[4:0], ksize: md[9:5], nsize: md[14:10]};
              q.push_back(me);
            end else m_ovf = 1;
          end
          default: begin
            if (md[1]) m_ovf = 0;
            if (md[2]) m_dz = 0;
          end
        endcase
      end
    end
  end

  // Compare process
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("cmd_valid", bus_if.cmd_valid, q.size() != 0);
      if (q.size() != 0) chk("cmd_head", dut_head(), q[0]);
      chk("rd_data", bus_if.system_bus_rd_data, m_rd);
    end
  end

  task automatic acc(input logic rdwr, input logic [4:0] off, input logic [31:0] d);
    @(negedge clk);
    bus_if.system_bus_en      = 1'b1;
    bus_if.system_bus_rdwr    = rdwr;
    bus_if.system_bus_addr    = {BASE[31:5], off};
    bus_if.system_bus_wr_data = d;
    @(posedge clk);
    #2;
    bus_if.system_bus_en   = 1'b0;
    bus_if.system_bus_rdwr = 1'b0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    acc(1'b1, off, d);
  endtask

  task automatic rd(input logic [4:0] off);
    acc(1'b0, off, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [4:0]  r_off;
  logic [4:0]  fm, fk, fn;
  logic [31:0] r_data;

  initial begin
    bus_if.system_bus_en      = 1'b0;
    bus_if.system_bus_rdwr    = 1'b0;
    bus_if.system_bus_addr    = '0;
    bus_if.system_bus_wr_data = '0;
    bus_if.cmd_ready          = 1'b0;
    bus_if.engine_busy        = 1'b0;
    #1;
    chk("reset_valid", bus_if.cmd_valid, 1'b0);
    chk("reset_head", dut_head(), '0);
    chk("reset_rd", bus_if.system_bus_rd_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    rd(5'h18);
    chk("done_after_reset", bus_if.system_bus_rd_data, 32'h1);

    // Single command
    wr(5'h00, 32'h0);
    wr(5'h04, 32'h1F4);
    wr(5'h08, 32'h3E8);
    wr(5'h0C, 32'd40);
    wr(5'h10, 32'd30);
    wr(5'h14, 32'h3);
    wr(5'h18, dim(16, 16, 16));
    chk("single_valid", bus_if.cmd_valid, 1'b1);
    chk("single_a", bus_if.cmd_a_addr, 32'h0);
    chk("single_b", bus_if.cmd_b_addr, 32'h1F4);
    chk("single_c", bus_if.cmd_c_addr, 32'h3E8);
    chk("single_as", bus_if.cmd_a_stride, 32'd40);
    chk("single_bs", bus_if.cmd_b_stride, 32'd30);
    chk("single_fl", {bus_if.cmd_first, bus_if.cmd_last}, 2'b11);
    chk("single_dims", {bus_if.cmd_msize, bus_if.cmd_ksize, bus_if.cmd_nsize}, 15'h4210);
    bus_if.cmd_ready = 1'b1;
    idle(1);
    chk("single_popped", bus_if.cmd_valid, 1'b0);
    bus_if.cmd_ready = 1'b0;

    // Fill and overflow
    for (int i = 1; i <= 4; i++) wr(5'h18, dim(5'(i), 2, 3));
    rd(5'h00);
    chk("fill_full", bus_if.system_bus_rd_data, 32'h1);
    wr(5'h18, dim(5, 2, 3));
    rd(5'h1C);
    chk("ovf_status", bus_if.system_bus_rd_data, 32'h3);
    chk("ovf_head", bus_if.cmd_msize, 5'd1);
    bus_if.cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("pop_order", bus_if.cmd_msize, 5'(i));
      idle(1);
    end
    chk("drained", bus_if.cmd_valid, 1'b0);
    bus_if.cmd_ready = 1'b0;
    wr(5'h1C, 32'h6);

    // Push and pop together while full
    for (int i = 1; i <= 4; i++) wr(5'h18, dim(5'(i), 1, 1));
    bus_if.cmd_ready = 1'b1;
    wr(5'h18, dim(9, 1, 1));
    bus_if.cmd_ready = 1'b0;
    rd(5'h00);
    chk("pushpop_full", bus_if.system_bus_rd_data, 32'h1);
    rd(5'h1C);
    chk("pushpop_no_ovf", bus_if.system_bus_rd_data, 32'h1);
    bus_if.cmd_ready = 1'b1;
    chk("pushpop_o1", bus_if.cmd_msize, 5'd2);
    idle(1);
    chk("pushpop_o2", bus_if.cmd_msize, 5'd3);
    idle(1);
    chk("pushpop_o3", bus_if.cmd_msize, 5'd4);
    idle(1);
    chk("pushpop_o4", bus_if.cmd_msize, 5'd9);
    idle(1);
    chk("pushpop_empty", bus_if.cmd_valid, 1'b0);
    bus_if.cmd_ready = 1'b0;

    // Zero dimension
    wr(5'h18, dim(3, 0, 3));
    chk("zero_no_valid", bus_if.cmd_valid, 1'b0);
    rd(5'h1C);
    chk("zero_status", bus_if.system_bus_rd_data, 32'h4);
    wr(5'h1C, 32'h4);
    rd(5'h1C);
    chk("zero_cleared", bus_if.system_bus_rd_data, 32'h0);

    // Done versus engine_busy
    bus_if.engine_busy = 1'b1;
    rd(5'h18);
    chk("busy_not_done", bus_if.system_bus_rd_data, 32'h0);
    bus_if.engine_busy = 1'b0;
    rd(5'h18);
    chk("idle_done", bus_if.system_bus_rd_data, 32'h1);

    // Reset with queued commands
    for (int i = 1; i <= 3; i++) wr(5'h18, dim(5'(i), 4, 4));
    chk("prereset_valid", bus_if.cmd_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_valid_drop", bus_if.cmd_valid, 1'b0);
    chk("rst_head_zero", dut_head(), '0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk("rst_queue_empty", bus_if.cmd_valid, 1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r_off = {$urandom_range(0, 7), 2'($urandom)};
      fm = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      fk = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      fn = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r_data = (r_off[4:2] == 3'd6) ? {$urandom_range(0, 131071), fn, fk, fm} : $urandom;
      bus_if.system_bus_en      = ($urandom_range(0, 3) != 0);
      bus_if.system_bus_rdwr    = $urandom_range(0, 1);
      bus_if.system_bus_addr    = ($urandom_range(0, 15) == 0) ? {BASE[31:6], 1'b1, r_off}
                                                               : {BASE[31:5], r_off};
      bus_if.system_bus_wr_data = r_data;
      bus_if.cmd_ready          = (c < 1500) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 2) != 0);
      bus_if.engine_busy        = $urandom_range(0, 1);
    end
    @(negedge clk);
    bus_if.system_bus_en = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
